// File: rtl/ps2_keyboard_rx_if.sv
// CPU-side read handshake for the PS/2 scancode FIFO.
// The master pops with rd_en; the slave presents the show-ahead head entry.
interface ps2_keyboard_rx_if;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_valid;

    modport master (output rd_en, input rd_data, input rd_valid);
    modport slave  (input rd_en, output rd_data, output rd_valid);
endinterface

// File: rtl/ps2_keyboard_rx.sv
// Receive-only PS/2 keyboard front end: pin synchronisers, clock glitch filter,
// 11-bit frame deserialiser with timeout, and a show-ahead scancode FIFO.
module ps2_keyboard_rx #(
    parameter int FIFO_DEPTH     = 8,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 16000
) (
    input  logic                   CLK_CPU,
    input  logic                   reset,
    input  logic                   keyboard_clock,
    input  logic                   keyboard_data,
    ps2_keyboard_rx_if.slave       rd_if,
    input  logic                   clear_errors,
    output logic                   overflow,
    output logic                   frame_error
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [3:0]    FLT_MAX  = 4'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

    // Odd parity: the eight data bits plus the parity bit must hold an odd number of ones.
    function automatic logic odd_parity_fail(input logic [7:0] b, input logic p);
        return ~(^{b, p});
    endfunction

    logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic          clk_f_q, clk_f_d, clk_f_prev_q;
    logic [3:0]    flt_cnt_q, flt_cnt_d;
    logic          fall_q, fall_d;
    state_e        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          perr_q, perr_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d, ferr_q, ferr_d;
    logic [7:0]    mem_q [FIFO_DEPTH];

    logic          push, pop, do_push, full, ovf_set, ferr_set;

    // Clock filter and registered falling-edge pulse.
    always_comb begin
        clk_f_d   = clk_f_q;
        flt_cnt_d = 4'd0;
        if (clk_s2_q == clk_f_q) begin
            flt_cnt_d = 4'd0;
        end else if (flt_cnt_q == FLT_MAX) begin
            clk_f_d   = clk_s2_q;
            flt_cnt_d = 4'd0;
        end else begin
            flt_cnt_d = flt_cnt_q + 4'd1;
        end
        fall_d = clk_f_prev_q & ~clk_f_q;
    end

    // Frame deserialiser FSM with inter-edge timeout.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        perr_d    = perr_q;
        tmo_d     = '0;
        push      = 1'b0;
        ferr_set  = 1'b0;
        case (state_q)
            IDLE: begin
                if (fall_q && !dat_s2_q) begin
                    state_d   = DATA;
                    bit_cnt_d = 3'd0;
                    shift_d   = 8'h00;
                end else if (fall_q) begin
                    ferr_set = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            DATA: begin
                if (fall_q) begin
                    shift_d = {dat_s2_q, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    state_d = DATA;
                end
            end
            PARITY: begin
                if (fall_q) begin
                    perr_d  = odd_parity_fail(shift_q, dat_s2_q);
                    state_d = STOP;
                end else begin
                    state_d = PARITY;
                end
            end
            STOP: begin
                if (fall_q) begin
                    state_d = IDLE;
                    if (dat_s2_q && !perr_q) begin
                        push = 1'b1;
                    end else begin
                        ferr_set = 1'b1;
                    end
                end else begin
                    state_d = STOP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // A stalled frame is abandoned without pushing its partial byte.
        if (state_q != IDLE) begin
            if (fall_q) begin
                tmo_d = '0;
            end else if (tmo_q == TMO_MAX) begin
                tmo_d    = '0;
                state_d  = IDLE;
                ferr_set = 1'b1;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end else begin
            tmo_d = '0;
        end
    end

    // FIFO pointer/count update and sticky flags; set beats clear.
    always_comb begin
        full     = (cnt_q == CNT_FULL);
        pop      = rd_if.rd_en & (cnt_q != '0);
        do_push  = push & (~full | pop);
        ovf_set  = push & full & ~pop;
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({do_push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (clear_errors) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
        if (ferr_set) begin
            ferr_d = 1'b1;
        end else if (clear_errors) begin
            ferr_d = 1'b0;
        end else begin
            ferr_d = ferr_q;
        end
    end

    // State registers with synchronous active-low reset; pin paths idle high.
    always_ff @(posedge CLK_CPU) begin
        if (!reset) begin
            clk_s1_q     <= 1'b1;
            clk_s2_q     <= 1'b1;
            dat_s1_q     <= 1'b1;
            dat_s2_q     <= 1'b1;
            clk_f_q      <= 1'b1;
            clk_f_prev_q <= 1'b1;
            flt_cnt_q    <= 4'd0;
            fall_q       <= 1'b0;
            state_q      <= IDLE;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            perr_q       <= 1'b0;
            tmo_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            ovf_q        <= 1'b0;
            ferr_q       <= 1'b0;
        end else begin
            clk_s1_q     <= keyboard_clock;
            clk_s2_q     <= clk_s1_q;
            dat_s1_q     <= keyboard_data;
            dat_s2_q     <= dat_s1_q;
            clk_f_q      <= clk_f_d;
            clk_f_prev_q <= clk_f_q;
            flt_cnt_q    <= flt_cnt_d;
            fall_q       <= fall_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            perr_q       <= perr_d;
            tmo_q        <= tmo_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            ovf_q        <= ovf_d;
            ferr_q       <= ferr_d;
        end
    end

    // FIFO storage; stale entries are masked by the empty check on the output.
    always_ff @(posedge CLK_CPU) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    assign rd_if.rd_valid = (cnt_q != '0);
    assign rd_if.rd_data  = (cnt_q != '0) ? mem_q[rd_ptr_q] : 8'h00;
    assign overflow       = ovf_q;
    assign frame_error    = ferr_q;

endmodule
